// File: rtl/sram_1rw1r_wmask_init.sv
// Purpose : behavioural 1RW + 1R SRAM with per-byte write masks and a post-reset zero-fill sequencer.
// Latency : read data requested at posedge N appears at negedge N and is consumed at posedge N+1.
// Backpr. : none; accesses sampled before init_done would rise are dropped, with a warning.
//
// Ports:
//   clk0                      shared clock; inputs sampled at posedge, array updated at negedge
//   rstb0                     synchronous active-low reset
//   csb0/web0/wmask0/addr0/din0/dout0   port 0 (read/write, byte-masked writes)
//   csb1/addr1/dout1          port 1 (read only)
//   init_done                 high once the array accepts accesses
//   collision                 one-cycle flag: port 0 write and port 1 read hit the same word
module sram_1rw1r_wmask_init #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS    = DATA_WIDTH / 8,
    parameter bit INIT_ON_RESET = 1'b1,
    parameter bit VERBOSE       = 1'b0
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  init_done,
    output logic                  collision
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    // Access registers: captured at posedge, consumed by the array at negedge.
    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_csb1;
    logic [ADDR_WIDTH-1:0] r_addr1;

    logic                  w_serve;
    logic                  w_collision;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET: w_state_nxt = INIT_ON_RESET ? ST_INIT : ST_READY;
            ST_INIT:  if (r_init_cnt == LP_LAST) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_RESET;
        endcase
    end

    // An access is served when the edge that samples it lands the machine in READY;
    // this makes the very edge on which init_done rises a live access edge.
    assign w_serve     = rstb0 && (w_state_nxt == ST_READY);
    assign w_collision = w_serve && !csb0 && !web0 && (|wmask0) && !csb1 && (addr0 == addr1);

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            r_state    <= ST_RESET;
            r_init_cnt <= '0;
            r_csb0     <= 1'b1;
            r_csb1     <= 1'b1;
            init_done  <= 1'b0;
            collision  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
            r_csb0    <= csb0 | ~w_serve;
            r_csb1    <= csb1 | ~w_serve;
            init_done <= w_serve;
            collision <= w_collision;
            if (!w_serve && !csb0) $warning("sram: port 0 access to 0x%0h ignored during init", addr0);
            if (!w_serve && !csb1) $warning("sram: port 1 access to 0x%0h ignored during init", addr1);
            if (w_collision) $warning("sram: port 0 write / port 1 read collision at 0x%0h", addr0);
        end
        r_web0   <= web0;
        r_wmask0 <= wmask0;
        r_addr0  <= addr0;
        r_din0   <= din0;
        r_addr1  <= addr1;
    end

    // Array side. Non-blocking reads and writes in one block give read-before-write
    // on a same-word port 0 write / port 1 read.
    always_ff @(negedge clk0) begin
        case (r_state)
            ST_RESET: begin
                dout0 <= '0;
                dout1 <= '0;
            end
            ST_INIT: r_mem[r_init_cnt] <= '0;
            default: begin
                if (!r_csb0 && r_web0) begin
                    dout0 <= r_mem[r_addr0];
                    if (VERBOSE) $info("sram: p0 read  0x%0h -> 0x%0h", r_addr0, r_mem[r_addr0]);
                end
                if (!r_csb1) begin
                    dout1 <= r_mem[r_addr1];
                    if (VERBOSE) $info("sram: p1 read  0x%0h -> 0x%0h", r_addr1, r_mem[r_addr1]);
                end
                if (!r_csb0 && !r_web0) begin
                    for (int i = 0; i < NUM_WMASKS; i++) begin
                        if (r_wmask0[i]) r_mem[r_addr0][8*i +: 8] <= r_din0[8*i +: 8];
                    end
                    if (VERBOSE) $info("sram: p0 write 0x%0h <- 0x%0h mask %b", r_addr0, r_din0, r_wmask0);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sram_1rw1r_wmask_init.sv
// Purpose : directed bench for sram_1rw1r_wmask_init with a per-cycle reference model.
// Latency : outputs checked just after each negedge, once the array has updated.
// Backpr. : none; every wait on the design is bounded by a cycle budget.
module tb_sram_1rw1r_wmask_init;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Instance A: default parameters (zero-fill on reset)
    logic        rstb0, csb0, web0, csb1;
    logic [1:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [15:0] din0, dout0, dout1;
    logic        init_done, collision;

    // Instance B: contents retained across reset
    logic        b_rstb0, b_csb0, b_web0, b_csb1;
    logic [1:0]  b_wmask0;
    logic [7:0]  b_addr0, b_addr1;
    logic [15:0] b_din0, b_dout0, b_dout1;
    logic        b_init_done, b_collision;

    sram_1rw1r_wmask_init dut_a (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0), .csb1(csb1), .addr1(addr1),
        .dout1(dout1), .init_done(init_done), .collision(collision)
    );

    sram_1rw1r_wmask_init #(.INIT_ON_RESET(1'b0)) dut_b (
        .clk0(clk0), .rstb0(b_rstb0), .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0),
        .addr0(b_addr0), .din0(b_din0), .dout0(b_dout0), .csb1(b_csb1), .addr1(b_addr1),
        .dout1(b_dout1), .init_done(b_init_done), .collision(b_collision)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs set beforehand are sampled at the posedge; results are
    // observable after the negedge.
    task automatic cyc();
        @(posedge clk0);
        @(negedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 2'b00; csb1 = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic rd0(input logic [7:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    endtask

    task automatic rd1(input logic [7:0] a);
        csb1 = 1'b0; addr1 = a;
    endtask

    // ---------------- reference model of instance A ----------------
    // m_k counts live edges since the last reset; the first 256 of them zero-fill
    // word m_k and drop any access, every later edge serves the ports.
    logic [15:0] m_mem [256];
    logic [15:0] m_d0, m_d1;
    logic        m_done, m_coll;
    int          m_k;
    bit          m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk0);
            if (!rstb0) begin
                m_valid = 1'b1;
                m_k = 0; m_done = 1'b0; m_coll = 1'b0; m_d0 = '0; m_d1 = '0;
            end else if (m_valid) begin
                if (m_k < 256) begin
                    m_mem[m_k] = '0;
                    m_k++;
                    m_done = 1'b0;
                    m_coll = 1'b0;
                end else begin
                    m_done = 1'b1;
                    m_coll = !csb0 && !web0 && (wmask0 != 2'b00) && !csb1 && (addr0 == addr1);
                    if (!csb0 && web0) m_d0 = m_mem[addr0];
                    if (!csb1)         m_d1 = m_mem[addr1];
                    if (!csb0 && !web0) begin
                        if (wmask0[0]) m_mem[addr0][7:0]  = din0[7:0];
                        if (wmask0[1]) m_mem[addr0][15:8] = din0[15:8];
                    end
                end
            end
            @(negedge clk0);
            #1;
            if (m_valid) begin
                chk("model_dout0", dout0, m_d0);
                chk("model_dout1", dout1, m_d1);
                chk("model_init_done", init_done, m_done);
                chk("model_collision", collision, m_coll);
            end
        end
    end

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int rise;

    initial begin
        rstb0 = 1'b0; addr0 = '0; addr1 = '0; din0 = '0; idle();
        b_rstb0 = 1'b0; b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0;
        b_addr0 = '0; b_addr1 = '0; b_din0 = '0; b_csb1 = 1'b1;

        // Reset for two cycles
        cyc(); cyc();
        chk("reset_init_done", init_done, 1'b0);
        chk("reset_dout0", dout0, 16'h0000);
        chk("reset_dout1", dout1, 16'h0000);
        chk("reset_collision", collision, 1'b0);

        // Release; a write at P3 must be dropped
        rstb0 = 1'b1;
        cyc(); cyc(); cyc();            // P0, P1, P2
        wr(8'h05, 16'hBEEF, 2'b11);
        cyc();                          // P3
        idle();
        rise = -1;
        for (int k = 4; k <= 300; k++) begin
            cyc();
            if (init_done) begin
                rise = k;
                break;
            end
        end
        chk("init_rise_edge", rise, 256);

        rd0(8'hFF); rd1(8'h05);
        cyc(); idle();
        chk("read_ff_after_init", dout0, 16'h0000);
        chk("write_during_init_ignored", dout1, 16'h0000);

        // Masked writes
        wr(8'h10, 16'hABCD, 2'b11); cyc();
        wr(8'h10, 16'h1234, 2'b01); cyc();
        idle(); rd1(8'h10); cyc(); idle();
        chk("masked_write_p1", dout1, 16'hAB34);
        rd0(8'h10); cyc(); idle();
        chk("masked_write_p0", dout0, 16'hAB34);

        // Collision: read-before-write on port 1
        wr(8'h20, 16'h5555, 2'b11); cyc();
        wr(8'h20, 16'hAAAA, 2'b11); rd1(8'h20); cyc(); idle();
        chk("collision_old_data", dout1, 16'h5555);
        chk("collision_flag", collision, 1'b1);
        cyc();
        chk("collision_drops", collision, 1'b0);
        rd1(8'h20); cyc(); idle();
        chk("collision_write_done", dout1, 16'hAAAA);

        // Zero-mask write alongside a same-address read: no-op, no flag
        wr(8'h20, 16'h0000, 2'b00); rd1(8'h20); cyc(); idle();
        chk("zero_mask_no_collision", collision, 1'b0);
        chk("zero_mask_no_write", dout1, 16'hAAAA);

        // Both ports reading one word is not a collision
        rd0(8'h20); rd1(8'h20); cyc(); idle();
        chk("dual_read_no_collision", collision, 1'b0);
        chk("dual_read_p0", dout0, 16'hAAAA);
        chk("dual_read_p1", dout1, 16'hAAAA);

        // Reset clears dout, then abort a fill at P100
        rstb0 = 1'b0; cyc();
        chk("reset2_dout0", dout0, 16'h0000);
        chk("reset2_dout1", dout1, 16'h0000);
        chk("reset2_init_done", init_done, 1'b0);
        rstb0 = 1'b1;
        repeat (100) cyc();             // P0..P99
        rstb0 = 1'b0; cyc();            // reset sampled at P100
        chk("midinit_init_done", init_done, 1'b0);
        rstb0 = 1'b1;
        rise = -1;
        for (int k = 0; k <= 300; k++) begin
            cyc();
            if (init_done) begin
                rise = k;
                break;
            end
        end
        chk("midinit_rise_edge", rise, 256);
        rd1(8'h20); cyc(); idle();
        chk("midinit_refilled", dout1, 16'h0000);

        // Instance B: no zero-fill, contents survive reset
        cyc();
        b_rstb0 = 1'b1;
        b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = 8'h40; b_din0 = 16'h0F0F; b_wmask0 = 2'b11;
        cyc();                          // P0: served immediately
        b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = 2'b00;
        chk("noinit_done_at_p0", b_init_done, 1'b1);
        b_rstb0 = 1'b0; cyc();
        chk("noinit_reset_done", b_init_done, 1'b0);
        chk("noinit_reset_dout0", b_dout0, 16'h0000);
        b_rstb0 = 1'b1;
        b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 8'h40;
        cyc();                          // P0 after second release
        b_csb0 = 1'b1;
        chk("noinit_done_again", b_init_done, 1'b1);
        chk("noinit_retained_p0", b_dout0, 16'h0F0F);
        b_csb1 = 1'b0; b_addr1 = 8'h40;
        cyc();
        b_csb1 = 1'b1;
        chk("noinit_retained_p1", b_dout1, 16'h0F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
